// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller.
//   run_state_e : controller state encoding (IDLE, HOLD, RUN, HALTED, TIMEOUT)
//   DEF_*       : default parameter values used by run_controller and stall_detector
//   STALL_CNT_W : width of the consecutive-equal-pc counter (STALL_LIMIT <= 255)
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALTED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_e;

    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_MAX_CYCLES   = 400;
    localparam int DEF_STALL_LIMIT  = 4;
    localparam int DEF_PC_W         = 64;
    localparam int DEF_CNT_W        = 32;
    localparam int STALL_CNT_W      = 8;

endpackage

// File: rtl/run_controller_stall_detector.sv
// Self-loop detector for the observed program counter.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   enable      : high while the core is running; low clears all history
//   pc          : program counter observed this cycle
//   stall_hit   : high in the cycle where pc has equalled the previous
//                 cycle's pc for STALL_LIMIT consecutive cycles
module stall_detector
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [PC_W-1:0] pc,
    output logic            stall_hit
);

    logic [PC_W-1:0]        prev_pc_reg;
    logic                   prev_valid_reg;
    logic [STALL_CNT_W-1:0] eq_cnt_reg;
    logic                   pc_same;

    // The first enabled cycle has no meaningful previous pc, so it never
    // counts as a repeat.
    assign pc_same = prev_valid_reg && (pc == prev_pc_reg);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            prev_pc_reg    <= '0;
            prev_valid_reg <= 1'b0;
            eq_cnt_reg     <= '0;
        end else begin
            prev_pc_reg    <= pc;
            prev_valid_reg <= 1'b1;
            eq_cnt_reg     <= pc_same ? (eq_cnt_reg + STALL_CNT_W'(1)) : '0;
        end
    end

    // eq_cnt_reg holds the number of earlier consecutive repeats; this cycle
    // is the STALL_LIMIT-th repeat when it already holds STALL_LIMIT-1.
    assign stall_hit = enable && pc_same &&
                       (eq_cnt_reg == STALL_CNT_W'(STALL_LIMIT - 1));

endmodule

// File: rtl/run_controller.sv
// Run controller: holds a core in reset, releases it for a bounded run and
// stops it on an explicit halt, a pc self-loop or cycle-budget exhaustion.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle pulse, begins a run from IDLE/HALTED/TIMEOUT
//   pc           : program counter observed from the core
//   halt_req     : explicit halt request from the core
//   core_reset   : reset to the core (high everywhere except RUN)
//   running      : state is RUN
//   done         : state is HALTED
//   timeout      : state is TIMEOUT
//   cycle_count  : RUN cycles completed in the current or last run
//   final_pc     : pc of the last RUN cycle, captured on leaving RUN
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int STALL_LIMIT  = DEF_STALL_LIMIT,
    parameter int PC_W         = DEF_PC_W,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_req,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  final_pc
);

    localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    run_state_e       state_reg, state_next;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [CNT_W-1:0]  cycle_count_reg;
    logic [PC_W-1:0]   final_pc_reg;
    logic              core_reset_reg, core_reset_next;
    logic              running_reg, running_next;
    logic              done_reg, done_next;
    logic              timeout_reg, timeout_next;

    logic stall_hit;
    logic hold_last;
    logic budget_last;
    logic enter_hold;
    logic leave_run;

    stall_detector #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_detector (
        .clk       (clk),
        .reset     (reset),
        .enable    (state_reg == ST_RUN),
        .pc        (pc),
        .stall_hit (stall_hit)
    );

    assign hold_last   = (hold_cnt_reg == HOLD_W'(RESET_CYCLES - 1));
    // This RUN cycle is the one that brings the count up to MAX_CYCLES.
    assign budget_last = (cycle_count_reg == CNT_W'(MAX_CYCLES - 1));
    assign enter_hold  = (state_reg != ST_HOLD) && (state_next == ST_HOLD);
    assign leave_run   = (state_reg == ST_RUN) && (state_next != ST_RUN);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_HOLD;
            ST_HOLD:    if (hold_last) state_next = ST_RUN;
            ST_RUN: begin
                // A halt in the same cycle the budget runs out is a halt.
                if (halt_req || stall_hit) begin
                    state_next = ST_HALTED;
                end else if (budget_last) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_HALTED,
            ST_TIMEOUT: if (start) state_next = ST_HOLD;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the flags are registered
    // alongside the state itself.
    always_comb begin
        core_reset_next = (state_next != ST_RUN);
        running_next    = (state_next == ST_RUN);
        done_next       = (state_next == ST_HALTED);
        timeout_next    = (state_next == ST_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset_reg <= 1'b1;
            running_reg    <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            core_reset_reg <= core_reset_next;
            running_reg    <= running_next;
            done_reg       <= done_next;
            timeout_reg    <= timeout_next;
        end
    end

    // Hold-cycle counter, run-cycle counter and final pc capture
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_reg    <= '0;
            cycle_count_reg <= '0;
            final_pc_reg    <= '0;
        end else begin
            if (enter_hold) begin
                hold_cnt_reg    <= '0;
                cycle_count_reg <= '0;
            end else if (state_reg == ST_HOLD) begin
                hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
            end else if (state_reg == ST_RUN) begin
                // Every RUN cycle counts, including the one that ends the run;
                // MAX_CYCLES bounds the count so it never wraps.
                cycle_count_reg <= cycle_count_reg + CNT_W'(1);
            end

            if (leave_run) begin
                final_pc_reg <= pc;
            end
        end
    end

    assign core_reset  = core_reset_reg;
    assign running     = running_reg;
    assign done        = done_reg;
    assign timeout     = timeout_reg;
    assign cycle_count = cycle_count_reg;
    assign final_pc    = final_pc_reg;

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter RESET_CYCLES, default 2, number of cycles core_reset is held after a start.
REQ-002 Parameter MAX_CYCLES, default 400, run-cycle budget before timeout; legal range 1..2^CNT_W-1.
REQ-003 Parameter STALL_LIMIT, default 4, consecutive cycles with unchanged pc that count as a self-loop halt; legal range 2..255.
REQ-004 Parameter PC_W, default 64, width of the observed program counter.
REQ-005 Parameter CNT_W, default 32, width of cycle_count.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse; begins a run from IDLE, HALTED or TIMEOUT.
REQ-009 pc  in  PC_W  program counter observed from the core.
REQ-010 halt_req  in  1  explicit halt request from the core (e.g. ebreak decoded).
REQ-011 core_reset  out  1  reset driven to the core, active-high.
REQ-012 running  out  1  high while state is RUN.
REQ-013 done  out  1  high while state is HALTED.
REQ-014 timeout  out  1  high while state is TIMEOUT.
REQ-015 cycle_count  out  CNT_W  number of RUN cycles completed in the current or last run.
REQ-016 final_pc  out  PC_W  pc captured on entry to HALTED or TIMEOUT.

Function
REQ-017 States: IDLE, HOLD, RUN, HALTED, TIMEOUT.
REQ-018 IDLE: core_reset=1; start -> HOLD.
REQ-019 HOLD: core_reset=1 for exactly RESET_CYCLES cycles, then -> RUN; cycle_count cleared on entry to HOLD.
REQ-020 RUN: core_reset=0; cycle_count increments by 1 each cycle; no wrap, since MAX_CYCLES bounds it.
REQ-021 RUN -> HALTED when halt_req=1, or when pc equals the previous cycle's pc for STALL_LIMIT consecutive cycles; the stall counter resets whenever pc changes.
REQ-022 RUN -> TIMEOUT when cycle_count reaches MAX_CYCLES without a halt; if a halt condition and the budget limit coincide in the same cycle, HALTED wins.
REQ-023 HALTED/TIMEOUT: core_reset=1; cycle_count and final_pc hold; start -> HOLD (rerun).
REQ-024 start in HOLD or RUN is ignored.
REQ-025 Outputs are registered; state flags change one cycle after the triggering condition is sampled.

Reset
REQ-026 reset=1 forces state IDLE: core_reset=1, running=0, done=0, timeout=0, cycle_count=0, final_pc=0, stall counter=0.
REQ-027 reset asserted mid-run aborts the run on the next edge, with no capture into final_pc.
REQ-028 reset has priority over start in the same cycle.

Structure
REQ-029 The state enum and default parameter constants are in shared package run_ctrl_pkg.
REQ-030 One sub-module, stall_detector, holds the previous-pc register and consecutive-equal counter and outputs stall_hit.
REQ-031 Target size: 120-250 lines of RTL.

Verification
REQ-032 reset 2 cycles, start pulse -> core_reset high exactly 2 cycles after HOLD entry, then running=1.
REQ-033 pc increments by 4 each cycle, halt_req at run cycle 10 -> done=1, cycle_count=10, final_pc equals pc at that cycle.
REQ-034 pc frozen at 0x40 from run cycle 5, STALL_LIMIT=4 -> done=1 by cycle 9, final_pc=0x40.
REQ-035 pc always changing, MAX_CYCLES=20 -> timeout=1, cycle_count=20, core_reset=1.
REQ-036 halt_req on the same cycle the budget is exhausted -> done=1, timeout=0.
REQ-037 reset at run cycle 7, then start -> IDLE, all outputs at reset values; the second run counts from 0.
